// File: rtl/as5311_pkg.sv
// Shared AS5311 SSI definitions: frame size, status bit indices, emulator
// state encoding and the frame parity helper.
package as5311_pkg;

  localparam int BITSIZE = 18;

  localparam int AS_OCF    = 4;
  localparam int AS_COF    = 3;
  localparam int AS_LIN    = 2;
  localparam int AS_MAGINC = 1;
  localparam int AS_MAGDEC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } sim_state_t;

  // Even parity over the 17 payload bits: the returned bit makes the 18-bit word even.
  function automatic logic even_parity(input logic [BITSIZE-2:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/as5311_sim_if.sv
// SSI bus between an AS5311 reader (master) and the sensor emulator (slave).
interface as5311_sim_if;
  logic as5311_clk;
  logic as5311_cs;
  logic as5311_do;
  logic as5311_do_oe;

  modport master (output as5311_clk, as5311_cs, input  as5311_do, as5311_do_oe);
  modport slave  (input  as5311_clk, as5311_cs, output as5311_do, as5311_do_oe);
endinterface

// File: rtl/as5311_sync.sv
// STAGES-flop synchroniser with rise/fall strobes of the synchronised level.
// Flops reset to 1 (idle level of the SSI lines); STAGES must be >= 2.
module as5311_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sreg;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '1;
      prev <= 1'b1;
    end else begin
      sreg <= {sreg[STAGES-2:0], d};
      prev <= sreg[STAGES-1];
    end
  end

  assign q    = sreg[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/as5311_sim.sv
// AS5311 SSI sensor emulator: serves 18-bit position/magnet frames to a reader.
// Optional feature: define AS5311_SIM_CHAIN_EN to add chain_in for daisy-chaining.
module as5311_sim
  import as5311_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  as5311_sim_if.slave ssi,
  input  logic [11:0] position,
  input  logic [11:0] magnet,
  input  logic [4:0]  status,
`ifdef AS5311_SIM_CHAIN_EN
  input  logic        chain_in,
`endif
  output logic        frame_done,
  output logic        frame_type,
  output logic [4:0]  frame_bits,
  output logic [7:0]  debug
);

  sim_state_t           state;
  logic [BITSIZE-1:0]   word;
  logic [4:0]           bitcnt;
  logic                 cur_type;
  logic                 armed;
  logic [SYNC_STAGES:0] settle;
  logic                 tail_bit;

  logic sclk_s, sclk_rise, sclk_fall_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [11:0] load_val;

  as5311_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .d(ssi.as5311_clk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  as5311_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .d(ssi.as5311_cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

`ifdef AS5311_SIM_CHAIN_EN
  logic chain_q;
  always_ff @(posedge clk) begin
    if (reset) chain_q <= 1'b0;
    else       chain_q <= chain_in;
  end
  assign tail_bit = chain_q;
`else
  assign tail_bit = 1'b0;
`endif

  assign load_val = sclk_s ? position : magnet;

  // Synchronisers come out of reset at the idle level, so a cs held low across
  // reset would look like a falling edge; armed requires a genuine high first.
  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      bitcnt     <= '0;
      cur_type   <= 1'b0;
      armed      <= 1'b0;
      settle     <= '0;
      frame_type <= 1'b0;
      frame_bits <= '0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && cs_s) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            cur_type   <= sclk_s;
            word       <= {load_val, status, even_parity({load_val, status})};
            bitcnt     <= 5'(BITSIZE);
            frame_bits <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_type <= cur_type;
          end else if (sclk_rise) begin
            word       <= word << 1;
            bitcnt     <= bitcnt - 5'd1;
            frame_bits <= (frame_bits == 5'd31) ? 5'd31 : frame_bits + 5'd1;
            if (bitcnt == 5'd1) state <= TAIL;
          end
        end
        TAIL: begin
          if (cs_rise) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_type <= cur_type;
          end else if (sclk_rise) begin
            frame_bits <= (frame_bits == 5'd31) ? 5'd31 : frame_bits + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ssi.as5311_do    = (state == IDLE)  ? 1'b1 :
                            (state == SHIFT) ? word[BITSIZE-1] : tail_bit;
  assign ssi.as5311_do_oe = (state != IDLE);
  assign debug            = {state, bitcnt, cs_s};

endmodule

// File: tb/tb_as5311_sim.sv
// Directed bench for as5311_sim: acts as the SSI reader and checks frames.
module tb_as5311_sim;
  import as5311_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] position, magnet;
  logic [4:0]  status;
  logic        frame_done, frame_type;
  logic [4:0]  frame_bits;
  logic [7:0]  debug;
  int          n_cmp = 0, n_bad = 0, done_cnt = 0, d0;
  logic [31:0] got;

  as5311_sim_if bus ();

`ifdef AS5311_SIM_CHAIN_EN
  logic chain_in = 1'b0;
`endif

  as5311_sim #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ssi(bus),
    .position(position), .magnet(magnet), .status(status),
`ifdef AS5311_SIM_CHAIN_EN
    .chain_in(chain_in),
`endif
    .frame_done(frame_done), .frame_type(frame_type),
    .frame_bits(frame_bits), .debug(debug)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Idle high, then drop cs with the reader clock at lvl (selects frame type).
  task automatic start_frame(input logic lvl);
    bus.as5311_clk = lvl;
    bus.as5311_cs  = 1'b1;
    cyc(8);
    bus.as5311_cs  = 1'b0;
    cyc(3);
  endtask

  // n reader clock rising edges, sampling do just before each rise.
  task automatic edges(input int n, input int chg_at, input logic [11:0] chg_pos,
                       output logic [31:0] bits);
    bits = '0;
    cyc(3);
    for (int i = 0; i < n; i++) begin
      if (bus.as5311_clk) begin
        bus.as5311_clk = 1'b0;
        cyc(6);
      end
      bits = {bits[30:0], bus.as5311_do};
      bus.as5311_clk = 1'b1;
      cyc(6);
      if (i + 1 == chg_at) position = chg_pos;
    end
  endtask

  task automatic end_frame();
    bus.as5311_cs = 1'b1;
    cyc(6);
  endtask

  initial begin
    reset = 1'b1;
    bus.as5311_clk = 1'b1;
    bus.as5311_cs  = 1'b1;
    position = '0; magnet = '0; status = '0;
    cyc(4);
    chk("rst_do", bus.as5311_do, 1);
    chk("rst_oe", bus.as5311_do_oe, 0);
    chk("rst_type", frame_type, 0);
    chk("rst_bits", frame_bits, 0);
    chk("rst_debug", debug, 8'h01);
    reset = 1'b0;
    cyc(6);
    chk("rst_done", done_cnt, 0);

    // Position frame
    position = 12'hA5C; status = 5'b10000; d0 = done_cnt;
    start_frame(1'b1);
    chk("pos_lat_do", bus.as5311_do, 1);
    chk("pos_lat_oe", bus.as5311_do_oe, 1);
    edges(BITSIZE, 0, 12'h0, got);
    chk("pos_word", got[17:0], 18'h29721);
    chk("pos_tail_do", bus.as5311_do, 0);
    chk("pos_nodone", done_cnt - d0, 0);
    end_frame();
    chk("pos_done", done_cnt - d0, 1);
    chk("pos_type", frame_type, 1);
    chk("pos_bits", frame_bits, 18);
    chk("pos_idle_do", bus.as5311_do, 1);
    chk("pos_idle_oe", bus.as5311_do_oe, 0);

    // Magnet frame
    magnet = 12'h3FF; status = 5'b0; d0 = done_cnt;
    start_frame(1'b0);
    edges(BITSIZE, 0, 12'h0, got);
    chk("mag_type_held", frame_type, 1);
    end_frame();
    chk("mag_word", got[17:0], 18'h0FFC0);
    chk("mag_type", frame_type, 0);
    chk("mag_done", done_cnt - d0, 1);

    // Inputs changing mid-frame must not leak into the word
    position = 12'h001; status = 5'b00101;
    start_frame(1'b1);
    edges(BITSIZE, 5, 12'hFFF, got);
    end_frame();
    chk("stab_word", got[17:0], 18'h0004B);

    // Aborted after 7 edges
    position = 12'hA5C; status = 5'b10000; d0 = done_cnt;
    start_frame(1'b1);
    edges(7, 0, 12'h0, got);
    end_frame();
    chk("abort_head", got[6:0], 7'h52);
    chk("abort_done", done_cnt - d0, 1);
    chk("abort_bits", frame_bits, 7);
    chk("abort_state", debug[7:6], 0);
    chk("abort_do", bus.as5311_do, 1);
    chk("abort_oe", bus.as5311_do_oe, 0);

    // Over-clocked magnet frame: 20 edges, last two samples from the tail
    magnet = 12'h800; status = 5'b01010;
    start_frame(1'b0);
    edges(20, 0, 12'h0, got);
    end_frame();
    chk("over_word", got[19:0], 20'h80054);
    chk("over_bits", frame_bits, 20);
    chk("over_type", frame_type, 0);

    // frame_bits saturates
    start_frame(1'b1);
    edges(33, 0, 12'h0, got);
    end_frame();
    chk("sat_bits", frame_bits, 31);

    // Reset mid-frame, cs held low through and after reset
    position = 12'hA5C; status = 5'b10000; d0 = done_cnt;
    start_frame(1'b1);
    edges(9, 0, 12'h0, got);
    reset = 1'b1;
    cyc(3);
    chk("mrst_do", bus.as5311_do, 1);
    chk("mrst_oe", bus.as5311_do_oe, 0);
    chk("mrst_bits", frame_bits, 0);
    chk("mrst_type", frame_type, 0);
    reset = 1'b0;
    cyc(12);
    chk("mrst_nodone", done_cnt - d0, 0);
    chk("mrst_nostart_do", bus.as5311_do, 1);
    chk("mrst_nostart_oe", bus.as5311_do_oe, 0);
    position = 12'h5A3;
    start_frame(1'b1);
    chk("mrst_lat_do", bus.as5311_do, 0);
    edges(BITSIZE, 0, 12'h0, got);
    end_frame();
    chk("mrst_word", got[17:0], 18'h168E1);
    chk("mrst_type2", frame_type, 1);
    chk("mrst_done", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
